// File: rtl/term_ctrl.sv
// term_ctrl: byte-stream terminal front end for the text engine.
// Decodes printable bytes and CR/LF/BS/FF, tracks the cursor, and owns
// VRAM port A for character writes, hardware clear and one-row scroll.
module term_ctrl #(
  parameter int          COLS  = 60,
  parameter int          ROWS  = 17,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_dv,
  output logic        o_ready,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_din,
  input  logic [7:0]  o_vram_dout,
  output logic        o_vram_clk,
  output logic        o_vram_ce,
  output logic        o_vram_wre,
  output logic        o_cursor_e
);

  localparam logic [5:0] XMAX = 6'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);
  localparam logic [4:0] YSCR = 5'(ROWS - 2);

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, SC_RD, SC_WR, SC_BLANK} state_t;

  state_t      r_state;
  logic [5:0]  r_cur_x, r_cx, r_rx, r_wx;
  logic [4:0]  r_cur_y, r_cy, r_ry, r_wy;
  logic        r_ph;
  logic        r_ready, r_ce, r_wre;
  logic [10:0] r_addr;
  logic [7:0]  r_din;
  logic        w_accept;

  assign w_accept    = i_dv & r_ready & (r_state == IDLE);
  assign o_ready     = r_ready;
  assign o_cursor_e  = r_ready;
  assign o_vram_addr = r_addr;
  assign o_vram_din  = r_din;
  assign o_vram_ce   = r_ce;
  assign o_vram_wre  = r_wre;
  assign o_vram_clk  = i_clk;

  // Control FSM. Outputs are registered: each edge presents the bus
  // operation for the cycle that follows. Scroll runs read/write in pairs
  // (R R W W) so the write data, which arrives one cycle after its read,
  // can be registered straight from the RAM output with no bubble cycles.
  // The pairing assumes COLS is even; scroll pointers rest at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_cur_x <= '0;  r_cur_y <= '0;
      r_cx    <= '0;  r_cy    <= '0;
      r_rx    <= '0;  r_ry    <= '0;
      r_wx    <= '0;  r_wy    <= '0;
      r_ph    <= 1'b0;
      r_ready <= 1'b0; r_ce <= 1'b0; r_wre <= 1'b0;
      r_addr  <= '0;   r_din <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_ready <= 1'b0; r_ce <= 1'b1; r_wre <= 1'b1;
          r_din   <= BLANK;
          r_addr  <= {r_cy, r_cx};
          if (r_cx == XMAX) begin
            r_cx <= '0;
            if (r_cy == YMAX) begin
              r_cy    <= '0;
              r_cur_x <= '0;
              r_cur_y <= '0;
              r_state <= IDLE;
            end else begin
              r_cy <= r_cy + 5'd1;
            end
          end else begin
            r_cx <= r_cx + 6'd1;
          end
        end
        IDLE: begin
          r_ready <= 1'b1; r_ce <= 1'b0; r_wre <= 1'b0;
          r_addr  <= {r_cur_y, r_cur_x};
          if (w_accept) begin
            if (i_data >= 8'h20) begin
              r_ready <= 1'b0; r_ce <= 1'b1; r_wre <= 1'b1;
              r_din   <= i_data;
              r_state <= WRITE;
            end else begin
              case (i_data)
                8'h0D: begin
                  r_cur_x <= '0;
                  r_addr  <= {r_cur_y, 6'd0};
                end
                8'h0A: begin
                  if (r_cur_y != YMAX) begin
                    r_cur_y <= r_cur_y + 5'd1;
                    r_addr  <= {r_cur_y + 5'd1, r_cur_x};
                  end else begin
                    // first scroll read issued right away
                    r_state <= SC_RD; r_ph <= 1'b1; r_rx <= 6'd1;
                    r_ready <= 1'b0; r_ce <= 1'b1; r_wre <= 1'b0;
                    r_addr  <= {5'd1, 6'd0};
                  end
                end
                8'h08: begin
                  if (r_cur_x != 6'd0) begin
                    r_cur_x <= r_cur_x - 6'd1;
                    r_addr  <= {r_cur_y, r_cur_x - 6'd1};
                  end
                end
                8'h0C: begin
                  r_ready <= 1'b0;
                  r_state <= CLEAR;
                end
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          if (r_cur_x != XMAX) begin
            r_cur_x <= r_cur_x + 6'd1;
            r_ready <= 1'b1; r_ce <= 1'b0; r_wre <= 1'b0;
            r_addr  <= {r_cur_y, r_cur_x + 6'd1};
            r_state <= IDLE;
          end else begin
            r_cur_x <= '0;
            if (r_cur_y != YMAX) begin
              r_cur_y <= r_cur_y + 5'd1;
              r_ready <= 1'b1; r_ce <= 1'b0; r_wre <= 1'b0;
              r_addr  <= {r_cur_y + 5'd1, 6'd0};
              r_state <= IDLE;
            end else begin
              r_state <= SC_RD; r_ph <= 1'b1; r_rx <= 6'd1;
              r_ce    <= 1'b1; r_wre <= 1'b0;
              r_addr  <= {5'd1, 6'd0};
            end
          end
        end
        SC_RD: begin
          r_ce   <= 1'b1; r_wre <= 1'b0;
          r_addr <= {r_ry + 5'd1, r_rx};
          if (r_rx == XMAX) begin
            r_rx <= '0;
            r_ry <= r_ry + 5'd1;
          end else begin
            r_rx <= r_rx + 6'd1;
          end
          r_ph <= ~r_ph;
          if (r_ph) r_state <= SC_WR;
        end
        SC_WR: begin
          r_ce   <= 1'b1; r_wre <= 1'b1;
          r_din  <= o_vram_dout;
          r_addr <= {r_wy, r_wx};
          if (r_wx == XMAX) begin
            r_wx <= '0;
            r_wy <= r_wy + 5'd1;
          end else begin
            r_wx <= r_wx + 6'd1;
          end
          r_ph <= ~r_ph;
          if (r_ph)
            r_state <= (r_wy == YSCR && r_wx == XMAX) ? SC_BLANK : SC_RD;
        end
        SC_BLANK: begin
          r_ce   <= 1'b1; r_wre <= 1'b1;
          r_din  <= BLANK;
          r_addr <= {YMAX, r_cx};
          if (r_cx == XMAX) begin
            r_cx <= '0;
            r_rx <= '0; r_ry <= '0;
            r_wx <= '0; r_wy <= '0;
            r_state <= IDLE;
          end else begin
            r_cx <= r_cx + 6'd1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: directed bench for term_ctrl with a behavioural VRAM.
module tb_term_ctrl;

  logic        clk = 1'b0;
  logic        rst, dv;
  logic [7:0]  data, dout, din;
  logic        ready, ce, wre, vclk, cur_e;
  logic [10:0] addr;

  always #5 clk = ~clk;

  term_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_dv(dv),
    .o_ready(ready), .o_vram_addr(addr), .o_vram_din(din),
    .o_vram_dout(dout), .o_vram_clk(vclk), .o_vram_ce(ce),
    .o_vram_wre(wre), .o_cursor_e(cur_e)
  );

  // VRAM: synchronous write; read data appears the cycle after the read
  logic [7:0] mem [0:2047];
  always @(posedge clk)
    if (ce) begin
      if (wre) mem[addr] <= din;
      else     dout      <= mem[addr];
    end

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  d;
    int          n;
    logic [10:0] exp;
  } vec_t;
  vec_t v [15];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < 4000) begin tick; cyc++; end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic send(input logic [7:0] b);
    int c;
    wait_ready(c);
    data = b; dv = 1'b1;
    tick;
    dv = 1'b0;
  endtask

  function automatic int cells_not(input logic [7:0] val);
    int n = 0;
    for (int y = 0; y < 17; y++)
      for (int x = 0; x < 60; x++)
        if (mem[y*64 + x] !== val) n++;
    return n;
  endfunction

  task automatic clear_check(input string nm);
    int nw = 0, badaddr = 0, baddat = 0, cyc = 0;
    logic [10:0] first = '1;
    while (!ready && cyc < 3000) begin
      if (ce && wre) begin
        if (nw == 0) first = addr;
        nw++;
        if (addr[5:0] >= 6'd60) badaddr++;
        if (din !== 8'h20) baddat++;
      end
      tick; cyc++;
    end
    chk({nm, "_ready"}, 32'(ready), 32'd1);
    chk({nm, "_count"}, 32'(nw), 32'd1020);
    chk({nm, "_first"}, 32'(first), 32'h000);
    chk({nm, "_xrange"}, 32'(badaddr), 32'd0);
    chk({nm, "_data"}, 32'(baddat), 32'd0);
    chk({nm, "_cells"}, 32'(cells_not(8'h20)), 32'd0);
    chk({nm, "_addr"}, 32'(addr), 32'h000);
  endtask

  task automatic run_vec(input int lo, input int hi);
    int c;
    for (int i = lo; i <= hi; i++) begin
      for (int k = 0; k < v[i].n; k++) send(v[i].d);
      wait_ready(c);
      chk($sformatf("vec%0d", i), 32'(addr), 32'(v[i].exp));
    end
  endtask

  initial begin
    int c, busy, xw, e0, e15, e16, eo;
    v[0]  = '{8'h0D, 1,  11'h000};
    v[1]  = '{8'h0A, 1,  11'h040};
    v[2]  = '{8'h0A, 1,  11'h080};
    v[3]  = '{8'h0A, 1,  11'h0C0};
    v[4]  = '{8'h01, 1,  11'h0C0};
    v[5]  = '{8'h1B, 1,  11'h0C0};
    v[6]  = '{8'h08, 1,  11'h0C0};
    v[7]  = '{8'h2E, 59, 11'h0FB};
    v[8]  = '{8'h0A, 1,  11'h140};
    v[9]  = '{8'h2D, 10, 11'h14A};
    v[10] = '{8'h08, 1,  11'h149};
    v[11] = '{8'h0D, 1,  11'h140};
    v[12] = '{8'h08, 1,  11'h140};
    v[13] = '{8'h0D, 1,  11'h140};
    v[14] = '{8'h0A, 1,  11'h180};

    // reset and power-on clear
    rst = 1'b1; dv = 1'b0; data = 8'h00;
    tick; tick;
    chk("rst_outs", {ready, ce, wre, cur_e, addr, din}, 32'd0);
    rst = 1'b0;
    clear_check("clr_rst");

    // printable at (0,0): write next cycle, ready two cycles after accept
    data = 8'h41; dv = 1'b1; tick; dv = 1'b0;
    chk("A_write", {ce, wre, addr, din}, {1'b1, 1'b1, 11'h000, 8'h41});
    chk("A_busy", {ready, cur_e}, 2'b00);
    tick;
    chk("A_ready", {ready, cur_e, addr}, {1'b1, 1'b1, 11'h001});
    chk("A_mem", 32'(mem[0]), 32'h41);

    run_vec(0, 7);

    // wrap from x=59 on row 3
    data = 8'h5A; dv = 1'b1; tick; dv = 1'b0;
    chk("Z_write", {ce, wre, addr, din}, {1'b1, 1'b1, 11'h0FB, 8'h5A});
    wait_ready(c);
    chk("Z_wrap", 32'(addr), 32'h100);

    run_vec(8, 14);

    // scroll setup: row 1 'B', row 16 x0..58 'C', cursor (7,16)
    send(8'h0C);
    clear_check("clr_ff");
    send(8'h0A);
    for (int i = 0; i < 60; i++) send(8'h42);
    for (int i = 0; i < 14; i++) send(8'h0A);
    for (int i = 0; i < 59; i++) send(8'h43);
    send(8'h0D);
    for (int i = 0; i < 7; i++) send(8'h43);
    wait_ready(c);
    chk("pre_scroll", 32'(addr), 32'h407);

    data = 8'h0A; dv = 1'b1; tick; dv = 1'b0;
    busy = 0; xw = 0;
    while (!ready && busy < 3000) begin
      if (ce && wre && din == 8'h58) xw++;
      if (busy == 100) begin data = 8'h58; dv = 1'b1; end
      else dv = 1'b0;
      tick; busy++;
    end
    dv = 1'b0;
    chk("scr_busy", 32'(busy), 32'd1980);
    chk("scr_cursor", {cur_e, addr}, {1'b1, 11'h407});
    chk("scr_drop", 32'(xw), 32'd0);
    e0 = 0; e15 = 0; e16 = 0; eo = 0;
    for (int x = 0; x < 60; x++) begin
      if (mem[x] !== 8'h42) e0++;
      if (mem[15*64 + x] !== ((x < 59) ? 8'h43 : 8'h20)) e15++;
      if (mem[16*64 + x] !== 8'h20) e16++;
      for (int y = 1; y < 15; y++) if (mem[y*64 + x] !== 8'h20) eo++;
    end
    chk("scr_row0", 32'(e0), 32'd0);
    chk("scr_row15", 32'(e15), 32'd0);
    chk("scr_row16", 32'(e16), 32'd0);
    chk("scr_rows", 32'(eo), 32'd0);

    // reset in the middle of a scroll write phase
    send(8'h0A);
    for (int i = 0; i < 500; i++) tick;
    c = 0;
    while (!(ce && wre) && c < 10) begin tick; c++; end
    chk("mid_wr_seen", {ce, wre}, 2'b11);
    rst = 1'b1; tick;
    chk("abort_outs", {ready, ce, wre, addr}, 32'd0);
    rst = 1'b0;
    clear_check("clr_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
